// File: rtl/counter_pkg.sv
// Shared counter types: terminal-behaviour mode, direction encodings and step-calc result flags.
// Pure declarations, no logic.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // term: the step crosses a bound (drives cout); wrap: pulse wrapped; sat: parked at a bound
    typedef struct packed {
        logic term;
        logic wrap;
        logic sat;
    } step_flags_t;

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of mod_counter; master drives controls, slave (the counter) returns status.
// Latency: none, wires only; no backpressure.
interface mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             wrapped;
    logic             sat;

    modport master (
        output clr, ld, ld_val, en, dir, step, limit,
        input  out, cout, wrapped, sat
    );

    modport slave (
        input  clr, ld, ld_val, en, dir, step, limit,
        output out, cout, wrapped, sat
    );

endinterface

// File: rtl/mod_step_calc.sv
// Next-value and bound-crossing arithmetic for one counter step in range 0..limit.
// Latency: purely combinational; no backpressure.
module mod_step_calc
    import counter_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter mode_e MODE  = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt,
    output step_flags_t      flags
);

    localparam bit             IS_SAT = (MODE == MODE_SAT);
    localparam logic [WIDTH:0] ONE_X  = (WIDTH + 1)'(1);

    logic [WIDTH:0] cur_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] span_x;
    logic [WIDTH:0] sum_x;
    logic           over_range;

    always_comb begin
        cur_x      = {1'b0, cur};
        step_x     = {1'b0, step};
        span_x     = {1'b0, limit} + ONE_X;
        sum_x      = cur_x + step_x;
        over_range = (cur > limit);
        nxt        = cur;
        flags      = '0;

        if (step != '0) begin
            if (dir == DIR_UP) begin
                // A count left above a lowered limit counts as an overflow but never as a wrap.
                if (over_range) begin
                    flags.term = 1'b1;
                    if (IS_SAT) begin
                        nxt       = limit;
                        flags.sat = 1'b1;
                    end else begin
                        nxt = '0;
                    end
                end else if (sum_x > {1'b0, limit}) begin
                    flags.term = 1'b1;
                    if (IS_SAT) begin
                        nxt       = limit;
                        flags.sat = 1'b1;
                    end else begin
                        nxt        = WIDTH'(sum_x - span_x);
                        flags.wrap = 1'b1;
                    end
                end else begin
                    nxt = sum_x[WIDTH-1:0];
                end
            end else begin
                if (over_range) begin
                    nxt = limit;
                end else if (cur >= step) begin
                    nxt = WIDTH'(cur - step);
                end else begin
                    flags.term = 1'b1;
                    if (IS_SAT) begin
                        nxt       = '0;
                        flags.sat = 1'b1;
                    end else begin
                        nxt        = WIDTH'(cur_x + span_x - step_x);
                        flags.wrap = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Programmable modulo/saturating up/down counter; priority rst > clr > ld > en > hold.
// Latency: out/wrapped/sat registered one cycle, cout combinational; no backpressure (en gates each step).
module mod_counter
    import counter_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter mode_e MODE  = MODE_WRAP
) (
    input  logic          clk,
    input  logic          rst,
    mod_counter_if.slave  bus
);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             wrapped_d;
    logic             wrapped_q;
    logic             sat_d;
    logic             sat_q;
    logic [WIDTH-1:0] calc_nxt;
    step_flags_t      calc_flags;
    logic             step_vld;

    mod_step_calc #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_step_calc (
        .cur   (out_q),
        .step  (bus.step),
        .limit (bus.limit),
        .dir   (bus.dir),
        .nxt   (calc_nxt),
        .flags (calc_flags)
    );

    // A zero-magnitude step is a hold: no movement, no wrap, no carry.
    assign step_vld = bus.en & (bus.step != '0);

    always_comb begin
        out_d     = out_q;
        wrapped_d = 1'b0;
        sat_d     = sat_q;
        if (bus.clr) begin
            out_d = '0;
            sat_d = 1'b0;
        end else if (bus.ld) begin
            out_d = (bus.ld_val > bus.limit) ? bus.limit : bus.ld_val;
            sat_d = 1'b0;
        end else if (step_vld) begin
            out_d     = calc_nxt;
            wrapped_d = calc_flags.wrap;
            sat_d     = calc_flags.sat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q     <= '0;
            wrapped_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            wrapped_q <= wrapped_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.wrapped = wrapped_q;
    assign bus.sat     = sat_q;
    assign bus.cout    = rst & ~bus.clr & ~bus.ld & step_vld & calc_flags.term;

endmodule

// File: tb/tb_mod_counter.sv
// Directed-vector scoreboard bench for mod_counter (WIDTH=4), one WRAP and one SAT instance.
// Driver queues expectations per vector; an independent monitor pops and compares.
module tb_mod_counter;
    import counter_pkg::*;

    localparam int W = 4;
    localparam bit T_WRAP = 1'b0;
    localparam bit T_SAT  = 1'b1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mod_counter_if #(.WIDTH(W)) bus_w ();
    mod_counter_if #(.WIDTH(W)) bus_s ();

    mod_counter #(.WIDTH(W), .MODE(MODE_WRAP)) u_wrap (.clk(clk), .rst(rst), .bus(bus_w));
    mod_counter #(.WIDTH(W), .MODE(MODE_SAT))  u_sat  (.clk(clk), .rst(rst), .bus(bus_s));

    typedef struct {
        string  nm;
        bit     tgt;
        bit     chk_cout;
        bit     e_cout;
    } cexp_t;

    typedef struct {
        string          nm;
        bit             tgt;
        logic [W-1:0]   e_out;
        bit             e_wr;
        bit             e_sat;
    } rexp_t;

    cexp_t cq[$];
    rexp_t rq[$];
    int    checks = 0;
    int    errors = 0;

    // Illegal stimulus guard: step may never exceed limit+1 while counting.
    always @(posedge clk) begin
        if (rst === 1'b1 && bus_w.en === 1'b1)
            assert ({1'b0, bus_w.step} <= {1'b0, bus_w.limit} + 5'd1) else $error("illegal step on wrap instance");
        if (rst === 1'b1 && bus_s.en === 1'b1)
            assert ({1'b0, bus_s.step} <= {1'b0, bus_s.limit} + 5'd1) else $error("illegal step on sat instance");
    end

    task automatic idle_all();
        bus_w.clr = 1'b0; bus_w.ld = 1'b0; bus_w.en = 1'b0;
        bus_s.clr = 1'b0; bus_s.ld = 1'b0; bus_s.en = 1'b0;
    endtask

    task automatic v(input string nm, input bit tgt, input bit rst_n, input bit clr, input bit ld,
                     input logic [W-1:0] ld_val, input bit en, input bit dir, input logic [W-1:0] step,
                     input logic [W-1:0] limit, input bit cc, input bit ec, input logic [W-1:0] eo,
                     input bit ew, input bit es);
        cexp_t c;
        rexp_t r;
        @(negedge clk);
        rst = rst_n;
        idle_all();
        if (tgt == T_WRAP) begin
            bus_w.clr = clr; bus_w.ld = ld; bus_w.ld_val = ld_val; bus_w.en = en;
            bus_w.dir = dir; bus_w.step = step; bus_w.limit = limit;
        end else begin
            bus_s.clr = clr; bus_s.ld = ld; bus_s.ld_val = ld_val; bus_s.en = en;
            bus_s.dir = dir; bus_s.step = step; bus_s.limit = limit;
        end
        c.nm = nm; c.tgt = tgt; c.chk_cout = cc; c.e_cout = ec;
        r.nm = nm; r.tgt = tgt; r.e_out = eo; r.e_wr = ew; r.e_sat = es;
        cq.push_back(c);
        rq.push_back(r);
    endtask

    task automatic cnt(input string nm, input bit tgt, input bit dir, input logic [W-1:0] step,
                       input logic [W-1:0] limit, input bit cc, input bit ec, input logic [W-1:0] eo,
                       input bit ew, input bit es);
        v(nm, tgt, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, dir, step, limit, cc, ec, eo, ew, es);
    endtask

    task automatic load(input string nm, input bit tgt, input logic [W-1:0] val,
                        input logic [W-1:0] limit, input logic [W-1:0] eo);
        v(nm, tgt, 1'b1, 1'b0, 1'b1, val, 1'b1, DIR_UP, 4'd1, limit, 1'b1, 1'b0, eo, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        cexp_t        c;
        rexp_t        r;
        logic         cout_a;
        logic [W-1:0] out_a;
        logic         wr_a;
        logic         sat_a;
        forever begin
            @(negedge clk);
            #2;
            if (cq.size() > 0) begin
                c = cq.pop_front();
                if (c.chk_cout) begin
                    cout_a = c.tgt ? bus_s.cout : bus_w.cout;
                    checks++;
                    if (cout_a !== c.e_cout) begin
                        errors++;
                        $display("FAIL %s cout: got %0b want %0b", c.nm, cout_a, c.e_cout);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (rq.size() > 0) begin
                r = rq.pop_front();
                out_a = r.tgt ? bus_s.out : bus_w.out;
                wr_a  = r.tgt ? bus_s.wrapped : bus_w.wrapped;
                sat_a = r.tgt ? bus_s.sat : bus_w.sat;
                checks++;
                if (out_a !== r.e_out || wr_a !== r.e_wr || sat_a !== r.e_sat) begin
                    errors++;
                    $display("FAIL %s out/wrapped/sat: got %0d/%0b/%0b want %0d/%0b/%0b",
                             r.nm, out_a, wr_a, sat_a, r.e_out, r.e_wr, r.e_sat);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst = 1'b0;
        idle_all();
        bus_w.ld_val = '0; bus_w.dir = 1'b0; bus_w.step = 4'd1; bus_w.limit = 4'd9;
        bus_s.ld_val = '0; bus_s.dir = 1'b0; bus_s.step = 4'd1; bus_s.limit = 4'd12;

        // reset overrides load/enable; cout gated while in reset
        v("rst_ld", T_WRAP, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 4'd1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        v("rst_cout_w", T_WRAP, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        v("rst_cout_s", T_SAT, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

        // WRAP: 0..9 then 0 with cout at 9 and wrapped one cycle later
        for (int i = 0; i < 10; i++)
            cnt($sformatf("up_lim9_%0d", i), T_WRAP, 1'b0, 4'd1, 4'd9, 1'b1, (i == 9), 4'((i + 1) % 10), (i == 9), 1'b0);
        cnt("up_after_wrap", T_WRAP, 1'b0, 4'd1, 4'd9, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        v("hold_en0", T_WRAP, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 4'd9, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        load("ld9", T_WRAP, 4'd9, 4'd9, 4'd9);
        cnt("step0_at_lim", T_WRAP, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        cnt("wrap_rem", T_WRAP, 1'b0, 4'd4, 4'd9, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        cnt("step_lim_p1", T_WRAP, 1'b0, 4'd10, 4'd9, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);

        // WRAP down by 3 from 1: 8, 5, 2, 9
        load("ld1", T_WRAP, 4'd1, 4'd9, 4'd1);
        cnt("dn3_a", T_WRAP, 1'b1, 4'd3, 4'd9, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
        cnt("dn3_b", T_WRAP, 1'b1, 4'd3, 4'd9, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
        cnt("dn3_c", T_WRAP, 1'b1, 4'd3, 4'd9, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        cnt("dn3_d", T_WRAP, 1'b1, 4'd3, 4'd9, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0);

        // load clamps to limit and masks cout; clr beats ld
        v("ld_clamp", T_WRAP, 1'b1, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 4'd1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        v("clr_wins", T_WRAP, 1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 4'd1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

        // limit lowered below the count
        load("ld6", T_WRAP, 4'd6, 4'd9, 4'd6);
        cnt("lim_drop_up", T_WRAP, 1'b0, 4'd1, 4'd4, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        cnt("lim_drop_next", T_WRAP, 1'b0, 4'd1, 4'd4, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        load("ld6b", T_WRAP, 4'd6, 4'd9, 4'd6);
        cnt("lim_drop_dn", T_WRAP, 1'b1, 4'd1, 4'd4, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0);

        // reset mid-count, then resume from 0
        load("ld7", T_WRAP, 4'd7, 4'd9, 4'd7);
        v("rst_mid", T_WRAP, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        cnt("resume1", T_WRAP, 1'b0, 4'd1, 4'd9, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        cnt("resume2", T_WRAP, 1'b0, 4'd1, 4'd9, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);

        // SAT: up by 5 from 10 under limit 12, held, then down to 7
        load("s_ld10", T_SAT, 4'd10, 4'd12, 4'd10);
        cnt("s_up5_a", T_SAT, 1'b0, 4'd5, 4'd12, 1'b1, 1'b1, 4'd12, 1'b0, 1'b1);
        cnt("s_up5_b", T_SAT, 1'b0, 4'd5, 4'd12, 1'b1, 1'b1, 4'd12, 1'b0, 1'b1);
        v("s_hold", T_SAT, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 4'd12, 1'b1, 1'b0, 4'd12, 1'b0, 1'b1);
        cnt("s_dn5", T_SAT, 1'b1, 4'd5, 4'd12, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0);

        // SAT underflow, held at 0, step 0 keeps sat, up from 0 clears it
        load("s_ld3", T_SAT, 4'd3, 4'd12, 4'd3);
        cnt("s_under_a", T_SAT, 1'b1, 4'd5, 4'd12, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        cnt("s_under_b", T_SAT, 1'b1, 4'd5, 4'd12, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        cnt("s_step0", T_SAT, 1'b0, 4'd0, 4'd12, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        cnt("s_up2", T_SAT, 1'b0, 4'd2, 4'd12, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);

        // ld and clr both drop sat
        cnt("s_under_c", T_SAT, 1'b1, 4'd5, 4'd12, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        load("s_ld4", T_SAT, 4'd4, 4'd12, 4'd4);
        cnt("s_under_d", T_SAT, 1'b1, 4'd5, 4'd12, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        v("s_clr", T_SAT, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 4'd12, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

        // step = limit+1, lowered limit, and reset clearing sat
        cnt("s_step13", T_SAT, 1'b0, 4'd13, 4'd12, 1'b1, 1'b1, 4'd12, 1'b0, 1'b1);
        load("s_ld6", T_SAT, 4'd6, 4'd12, 4'd6);
        cnt("s_lim_drop", T_SAT, 1'b0, 4'd1, 4'd4, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1);
        v("s_rst", T_SAT, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        cnt("s_resume", T_SAT, 1'b0, 4'd1, 4'd12, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);

        @(negedge clk);
        idle_all();
        repeat (3) @(negedge clk);
        checks++;
        if (cq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending entries want 0/0", cq.size(), rq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
